// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - shared constants and helpers for the LED sequencer
package led_seq_pkg;

  localparam logic [2:0] OFF_PAT_LO = 3'd0;
  localparam logic [2:0] OFF_PAT_HI = 3'd1;
  localparam logic [2:0] OFF_CTRL   = 3'd2;
  localparam logic [2:0] OFF_PERIOD = 3'd3;
  localparam logic [2:0] OFF_STEPS  = 3'd4;
  localparam logic [2:0] OFF_STATUS = 3'd5;
  localparam logic [7:0] NUM_REGS   = 8'd6;

  localparam int CTRL_MODE_LSB = 0;
  localparam int CTRL_MODE_MSB = 1;
  localparam int CTRL_EN_BIT   = 2;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_ROTL   = 2'd2,
    MODE_ROTR   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Blink keeps CUR and only flips the phase, so it falls into the default arm.
  function automatic logic [15:0] step_pattern(input mode_e mode, input logic [15:0] cur);
    case (mode)
      MODE_ROTL: return {cur[14:0], cur[15]};
      MODE_ROTR: return {cur[0], cur[15:1]};
      default:   return cur;
    endcase
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// rtl/led_tick_gen.sv - prescaler producing a one-cycle tick every PRESCALE clocks
module led_tick_gen #(
  parameter int PRESCALE = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = !clr_i && (cnt_q == LAST);
    cnt_d  = cnt_q + CW'(1);
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - bus-mapped LED pattern sequencer (static/blink/rotate)
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'hC4,
  parameter int         PRESCALE  = 50000
) (
  input  logic        CLK,
  input  logic        RESET,
  inout  wire  [7:0]  BUS_DATA,
  input  logic [7:0]  BUS_ADDR,
  input  logic        BUS_WE,
  output logic [15:0] LED_OUT
);

  logic [7:0]  offset;
  logic [2:0]  off;
  logic        in_range, wr_en;
  logic        wr_lo, wr_hi, wr_ctrl, wr_period, wr_steps;

  logic [7:0]  pat_lo_q, pat_lo_d, pat_hi_q, pat_hi_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [7:0]  period_q, period_d, steps_q, steps_d;
  state_e      state_q, state_d;
  logic [15:0] cur_q, cur_d, led_q, led_d, pat_new;
  logic [7:0]  per_cnt_q, per_cnt_d, step_cnt_q, step_cnt_d, step_sat, per_eff;
  logic        phase_q, phase_d;
  logic        oe_q, oe_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        tick, tick_clr, restart, enable;
  mode_e       mode;

  // Subtracting the base makes the window check immune to address wrap-around.
  assign offset    = BUS_ADDR - BASE_ADDR;
  assign in_range  = (offset < NUM_REGS);
  assign off       = offset[2:0];
  assign wr_en     = in_range && BUS_WE;
  assign wr_lo     = wr_en && (off == OFF_PAT_LO);
  assign wr_hi     = wr_en && (off == OFF_PAT_HI);
  assign wr_ctrl   = wr_en && (off == OFF_CTRL);
  assign wr_period = wr_en && (off == OFF_PERIOD);
  assign wr_steps  = wr_en && (off == OFF_STEPS);

  assign enable   = ctrl_q[CTRL_EN_BIT];
  assign mode     = mode_e'(ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB]);
  assign pat_new  = {wr_hi ? BUS_DATA : pat_hi_q, wr_lo ? BUS_DATA : pat_lo_q};
  assign restart  = (state_q != ST_IDLE) && (wr_lo || wr_hi || wr_ctrl || wr_period);
  assign tick_clr = (state_q == ST_IDLE) || restart;
  assign per_eff  = (period_q == 8'd0) ? 8'd1 : period_q;
  assign step_sat = (step_cnt_q == 8'hFF) ? step_cnt_q : step_cnt_q + 8'd1;

  led_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk_i  (CLK),
    .rst_ni (RESET),
    .clr_i  (tick_clr),
    .tick_o (tick)
  );

  always_comb begin
    pat_lo_d = pat_lo_q;
    pat_hi_d = pat_hi_q;
    ctrl_d   = ctrl_q;
    period_d = period_q;
    steps_d  = steps_q;
    if (wr_lo)     pat_lo_d = BUS_DATA;
    if (wr_hi)     pat_hi_d = BUS_DATA;
    if (wr_ctrl)   ctrl_d   = BUS_DATA[2:0];
    if (wr_period) period_d = BUS_DATA;
    if (wr_steps)  steps_d  = BUS_DATA;
  end

  // A register write during RUN/DONE takes priority over a step due on the same edge.
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    per_cnt_d  = per_cnt_q;
    step_cnt_d = step_cnt_q;
    phase_d    = phase_q;
    case (state_q)
      ST_IDLE: begin
        cur_d      = pat_new;
        per_cnt_d  = 8'd0;
        step_cnt_d = 8'd0;
        phase_d    = 1'b1;
        if (enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (restart) begin
          cur_d      = pat_new;
          per_cnt_d  = 8'd0;
          step_cnt_d = 8'd0;
          phase_d    = 1'b1;
        end else if (tick) begin
          if (per_cnt_q == per_eff - 8'd1) begin
            per_cnt_d  = 8'd0;
            cur_d      = step_pattern(mode, cur_q);
            phase_d    = (mode == MODE_BLINK) ? !phase_q : phase_q;
            step_cnt_d = step_sat;
            if ((steps_q != 8'd0) && (step_sat == steps_q)) state_d = ST_DONE;
          end else begin
            per_cnt_d = per_cnt_q + 8'd1;
          end
        end
      end
      ST_DONE: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (restart) begin
          state_d    = ST_RUN;
          cur_d      = pat_new;
          per_cnt_d  = 8'd0;
          step_cnt_d = 8'd0;
          phase_d    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    led_d = cur_q;
    if (state_q == ST_IDLE)                      led_d = {pat_hi_q, pat_lo_q};
    else if ((mode == MODE_BLINK) && !phase_q)   led_d = 16'h0000;
  end

  always_comb begin
    oe_d    = in_range && !BUS_WE;
    rdata_d = 8'h00;
    case (off)
      OFF_PAT_LO: rdata_d = pat_lo_q;
      OFF_PAT_HI: rdata_d = pat_hi_q;
      OFF_CTRL:   rdata_d = {5'b00000, ctrl_q};
      OFF_PERIOD: rdata_d = period_q;
      OFF_STEPS:  rdata_d = steps_q;
      OFF_STATUS: rdata_d = {step_cnt_q[5:0], state_q};
      default:    rdata_d = 8'h00;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pat_lo_q   <= 8'h00;
      pat_hi_q   <= 8'h00;
      ctrl_q     <= 3'b000;
      period_q   <= 8'h00;
      steps_q    <= 8'h00;
      state_q    <= ST_IDLE;
      cur_q      <= 16'h0000;
      per_cnt_q  <= 8'h00;
      step_cnt_q <= 8'h00;
      phase_q    <= 1'b0;
      led_q      <= 16'h0000;
      oe_q       <= 1'b0;
      rdata_q    <= 8'h00;
    end else begin
      pat_lo_q   <= pat_lo_d;
      pat_hi_q   <= pat_hi_d;
      ctrl_q     <= ctrl_d;
      period_q   <= period_d;
      steps_q    <= steps_d;
      state_q    <= state_d;
      cur_q      <= cur_d;
      per_cnt_q  <= per_cnt_d;
      step_cnt_q <= step_cnt_d;
      phase_q    <= phase_d;
      led_q      <= led_d;
      oe_q       <= oe_d;
      rdata_q    <= rdata_d;
    end
  end

  assign LED_OUT  = led_q;
  assign BUS_DATA = (oe_q && !BUS_WE) ? rdata_q : 8'hzz;

endmodule

// File: tb/tb_led_sequencer.sv
// tb/tb_led_sequencer.sv - self-checking bench for led_sequencer
module tb_led_sequencer;

  localparam int PRESCALE = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic        we = 1'b0;
  logic [7:0]  wdat = 8'h00;
  logic        drv = 1'b0;
  logic [15:0] led;
  logic [7:0]  rv;
  wire  [7:0]  bus;

  int n_tests = 0;
  int n_fail  = 0;

  assign bus = drv ? wdat : 8'hzz;
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (bus[g]);
  end

  always #5 clk = ~clk;

  led_sequencer #(.BASE_ADDR(8'hC4), .PRESCALE(PRESCALE)) dut (
    .CLK      (clk),
    .RESET    (rst_n),
    .BUS_DATA (bus),
    .BUS_ADDR (addr),
    .BUS_WE   (we),
    .LED_OUT  (led)
  );

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [15:0] led;
    logic [1:0]  kind;
    logic [7:0]  rd;
  } vec_t;

  vec_t tbl[18];

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_rel(input string nm);
    n_tests++;
    if (!(bus === 8'hFF || bus === 8'hzz)) begin
      n_fail++;
      $display("FAIL %s: got %h expected released bus", nm, bus);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    addr = a; wdat = d; we = 1'b1; drv = 1'b1;
    @(negedge clk);
    we = 1'b0; drv = 1'b0; addr = 8'h00;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    addr = a; we = 1'b0;
    @(negedge clk);
    d = bus;
    addr = 8'h00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          we    addr   data   led       kind  rd
    tbl[0]  = '{1'b1, 8'hC4, 8'hA5, 16'h0000, 2'd0, 8'h00};
    tbl[1]  = '{1'b1, 8'hC5, 8'h3C, 16'h00A5, 2'd0, 8'h00};
    tbl[2]  = '{1'b0, 8'hC4, 8'h00, 16'h3CA5, 2'd1, 8'hA5};
    tbl[3]  = '{1'b0, 8'hC5, 8'h00, 16'h3CA5, 2'd1, 8'h3C};
    tbl[4]  = '{1'b0, 8'h00, 8'h00, 16'h3CA5, 2'd2, 8'h00};
    tbl[5]  = '{1'b1, 8'hC7, 8'h07, 16'h3CA5, 2'd0, 8'h00};
    tbl[6]  = '{1'b0, 8'hC7, 8'h00, 16'h3CA5, 2'd1, 8'h07};
    tbl[7]  = '{1'b1, 8'hC8, 8'h05, 16'h3CA5, 2'd0, 8'h00};
    tbl[8]  = '{1'b0, 8'hC8, 8'h00, 16'h3CA5, 2'd1, 8'h05};
    tbl[9]  = '{1'b0, 8'hC9, 8'h00, 16'h3CA5, 2'd1, 8'h00};
    tbl[10] = '{1'b0, 8'hC3, 8'h00, 16'h3CA5, 2'd2, 8'h00};
    tbl[11] = '{1'b0, 8'hCA, 8'h00, 16'h3CA5, 2'd2, 8'h00};
    tbl[12] = '{1'b1, 8'hC9, 8'hFF, 16'h3CA5, 2'd0, 8'h00};
    tbl[13] = '{1'b0, 8'hC9, 8'h00, 16'h3CA5, 2'd1, 8'h00};
    tbl[14] = '{1'b1, 8'hC6, 8'hF8, 16'h3CA5, 2'd0, 8'h00};
    tbl[15] = '{1'b0, 8'hC6, 8'h00, 16'h3CA5, 2'd1, 8'h00};
    tbl[16] = '{1'b0, 8'hC4, 8'h00, 16'h3CA5, 2'd1, 8'hA5};
    tbl[17] = '{1'b0, 8'h00, 8'h00, 16'h3CA5, 2'd2, 8'h00};

    wait_n(2);
    chk16("reset_led", led, 16'h0000);
    chk_rel("reset_bus");
    rst_n = 1'b1;

    // Static mode, register access and bus decode window
    for (int i = 0; i < 18; i++) begin
      addr = tbl[i].addr; we = tbl[i].we; wdat = tbl[i].data; drv = tbl[i].we;
      @(negedge clk);
      chk16($sformatf("vec%0d_led", i), led, tbl[i].led);
      if (tbl[i].kind == 2'd1) chk8($sformatf("vec%0d_rd", i), bus, tbl[i].rd);
      if (tbl[i].kind == 2'd2) chk_rel($sformatf("vec%0d_release", i));
    end
    we = 1'b0; drv = 1'b0; addr = 8'h00;

    // Blink with PERIOD=0
    wr(8'hC4, 8'hFF); wr(8'hC5, 8'hFF); wr(8'hC7, 8'h00); wr(8'hC8, 8'h00);
    wr(8'hC6, 8'h05);
    wait_n(5);  chk16("blink_n5", led, 16'hFFFF);
    wait_n(1);  chk16("blink_n6", led, 16'h0000);
    wait_n(3);  chk16("blink_n9", led, 16'h0000);
    wait_n(1);  chk16("blink_n10", led, 16'hFFFF);
    wait_n(3);  chk16("blink_n13", led, 16'hFFFF);
    wait_n(1);  chk16("blink_n14", led, 16'h0000);
    wr(8'hC6, 8'h01);
    wait_n(2);  chk16("blink_off_led", led, 16'hFFFF);
    rd(8'hC9, rv); chk8("blink_off_status", rv, 8'h00);

    // Rotate-left with step limit
    wr(8'hC4, 8'h01); wr(8'hC5, 8'h00); wr(8'hC7, 8'h02); wr(8'hC8, 8'h03);
    wr(8'hC6, 8'h06);
    wait_n(9);  chk16("rotl_n9", led, 16'h0001);
    wait_n(1);  chk16("rotl_n10", led, 16'h0002);
    wait_n(7);  chk16("rotl_n17", led, 16'h0002);
    wait_n(1);  chk16("rotl_n18", led, 16'h0004);
    wait_n(7);  chk16("rotl_n25", led, 16'h0004);
    wait_n(1);  chk16("rotl_n26", led, 16'h0008);
    wait_n(14); chk16("rotl_hold", led, 16'h0008);
    rd(8'hC9, rv); chk8("rotl_done_status", rv, 8'h0E);

    // Restart from DONE
    wr(8'hC6, 8'h06);
    chk16("restart_n0", led, 16'h0008);
    wait_n(1);  chk16("restart_n1", led, 16'h0001);
    rd(8'hC9, rv); chk8("restart_status_run", rv, 8'h01);
    wait_n(6);  chk16("restart_n8", led, 16'h0001);
    wait_n(1);  chk16("restart_n9", led, 16'h0002);
    wait_n(7);  chk16("restart_n16", led, 16'h0002);
    wait_n(1);  chk16("restart_n17", led, 16'h0004);
    wait_n(8);  chk16("restart_n25", led, 16'h0008);
    wait_n(10);
    rd(8'hC9, rv); chk8("restart_done_status", rv, 8'h0E);

    // Asynchronous reset mid-RUN while a read is being driven
    wr(8'hC6, 8'h06);
    wait_n(10); chk16("prereset_led", led, 16'h0002);
    addr = 8'hC4; we = 1'b0;
    @(posedge clk); #2;
    chk8("prereset_drive", bus, 8'h01);
    rst_n = 1'b0;
    #1;
    chk16("reset_async_led", led, 16'h0000);
    chk_rel("reset_async_bus");
    addr = 8'h00;
    wait_n(2);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rd(8'(8'hC4 + i), rv);
      chk8($sformatf("post_reset_reg%0d", i), rv, 8'h00);
    end
    chk16("post_reset_led", led, 16'h0000);

    // Write colliding with a due step in rotate-right
    wr(8'hC4, 8'h00); wr(8'hC5, 8'h80); wr(8'hC7, 8'h01);
    wr(8'hC6, 8'h07);
    wait_n(5);  chk16("coll_n5", led, 16'h8000);
    wait_n(1);  chk16("coll_n6", led, 16'h4000);
    wait_n(2);
    wr(8'hC5, 8'h40);
    rd(8'hC9, rv); chk8("coll_status", rv, 8'h01);
    chk16("coll_n10", led, 16'h4000);
    wait_n(3);  chk16("coll_n13", led, 16'h4000);
    wait_n(1);  chk16("coll_n14", led, 16'h2000);
    rd(8'hC9, rv); chk8("coll_status_after", rv, 8'h05);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
